sram_sync: RTL
==============

SRAM_SYNC -- requirements
Module: sram_sync

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 8, address width in bits; depth DEPTH = 2**ADDR_W words.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port cs  input  1  chip select, active-high; gates rd and wr, not clr.
REQ-006 The block SHALL have port wr  input  1  write request, active-high, sampled on clk edge.
REQ-007 The block SHALL have port rd  input  1  read request, active-high, sampled on clk edge.
REQ-008 The block SHALL have port addr  input  ADDR_W  word address.
REQ-009 The block SHALL have port din  input  DATA_W  write data.
REQ-010 The block SHALL have port clr  input  1  clear-all request, active-high, sampled on clk edge.
REQ-011 The block SHALL have port dout  output  DATA_W  registered read data.
REQ-012 The block SHALL have port dout_valid  output  1  high for one cycle when dout was updated by the preceding edge.
REQ-013 The block SHALL have port busy  output  1  high while the clear sequence runs.

Function
REQ-014 The block SHALL implement a two-state FSM: IDLE and CLEAR; busy SHALL equal (state == CLEAR), registered.
REQ-015 In IDLE, cs=1, wr=1, clr=0 at an edge, the block SHALL write mem[addr] <= din at that edge.
REQ-016 In IDLE, cs=1, rd=1, wr=0, clr=0 at edge t, the block SHALL drive dout = mem[addr] and dout_valid=1 after edge t (1-cycle latency).
REQ-017 In IDLE, cs=1, wr=1, rd=1, clr=0, the block SHALL write din to mem[addr] and drive dout = din, dout_valid=1 after the same edge (write-first).
REQ-018 With cs=0, or rd=0 and wr=0, the block SHALL leave memory unchanged, hold dout, and drive dout_valid=0 after the edge.
REQ-019 dout SHALL hold its last value whenever dout_valid=0.
REQ-020 In IDLE, clr=1 at an edge SHALL move the FSM to CLEAR with clear counter = 0; any rd/wr sampled at that edge SHALL be discarded (no write, dout_valid=0).
REQ-021 In CLEAR, each edge SHALL write mem[counter] <= 0 and increment the counter; the edge that writes address DEPTH-1 SHALL return the FSM to IDLE.
REQ-022 busy SHALL be high for exactly DEPTH consecutive cycles per clear sequence.
REQ-023 In CLEAR, rd, wr, cs and clr SHALL be ignored (no memory write from din, no queuing, dout held, dout_valid=0).
REQ-024 The clear counter SHALL be ADDR_W+1 bits wide or otherwise terminate without wrap-around re-entry; no address SHALL be cleared twice per sequence.
REQ-025 An access issued on the first IDLE cycle after CLEAR SHALL be serviced normally.
REQ-026 Addresses SHALL be used unsigned, full range 0..DEPTH-1; no out-of-range case exists.

Reset
REQ-027 rst=1 SHALL immediately, without a clock edge, force state=IDLE, clear counter=0, dout=0, dout_valid=0, busy=0.
REQ-028 Reset SHALL NOT alter memory contents; reset during CLEAR SHALL abort the sequence, leaving addresses already cleared at 0 and the remainder unchanged.
REQ-029 The first edge after rst deasserts SHALL be a normal IDLE edge.

Verification
REQ-030 Write/read: addr=8'h9A, din=8'hB5, wr=1 one cycle; then rd=1 -> dout=8'hB5, dout_valid=1 exactly one cycle after the read edge.
REQ-031 Overwrite and write-first: write 8'hB0 to 8'h9A with rd=1 the same cycle -> dout=8'hB0 after that edge; later read of 8'h9A returns 8'hB0.
REQ-032 cs gating: cs=0, wr=1, din=8'hFF, addr=8'h9A -> later read with cs=1 returns 8'hB0; dout_valid=0 during cs=0 cycles.
REQ-033 Clear (ADDR_W=4): fill all 16 words with 8'hA5, pulse clr -> busy high exactly 16 cycles, rd/wr during busy ignored, then all 16 reads return 8'h00.
REQ-034 Reset mid-clear (ADDR_W=4, memory filled with 8'hA5): assert rst after 5 CLEAR cycles -> busy=0, dout=0 at once; addresses 0-4 read 8'h00, 5-15 read 8'hA5.
REQ-035 Simultaneous clr and wr in IDLE: clr=1, wr=1, addr=3, din=8'h77 -> no write of 8'h77; after clear, addr 3 reads 8'h00.

Source files
------------

// File: rtl/sram_sync.sv
// ---------------------------------------------------------------------------
// sram_sync: single-port synchronous SRAM with registered read data and a
// hardware clear-all sequence that zeroes every word, one word per clock.
//
// Ports
//   clk         single clock, all state changes on the rising edge
//   rst         asynchronous, active-high reset (memory contents are kept)
//   cs          chip select, gates rd/wr (clr is not gated)
//   wr          write request
//   rd          read request (write-first when issued together with wr)
//   addr        word address, ADDR_W bits
//   din         write data, DATA_W bits
//   clr         clear-all request, starts the clear sequence
//   dout        registered read data, holds when dout_valid is low
//   dout_valid  high for one cycle after the edge that updated dout
//   busy        high while the clear sequence runs (DEPTH cycles)
// ---------------------------------------------------------------------------
module sram_sync #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              wr,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    input  logic              clr,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    // One spare bit so the counter can never wrap back into the address range.
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic               dout_valid_q, dout_valid_d;
    logic               busy_q;

    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic               mem_we_c;
    logic [ADDR_W-1:0]  mem_waddr_c;
    logic [DATA_W-1:0]  mem_wdata_c;

    // State, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= (state_d == ST_CLEAR);
        end
    end

    // Next-state, memory write port and read-data selection.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        mem_we_c     = 1'b0;
        mem_waddr_c  = addr;
        mem_wdata_c  = din;

        unique case (state_q)
            ST_IDLE: begin
                if (clr) begin
                    // rd/wr sampled with clr are dropped.
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else if (cs) begin
                    if (wr) begin
                        mem_we_c = 1'b1;
                    end
                    if (rd) begin
                        dout_valid_d = 1'b1;
                        // Write-first: a same-edge write forwards din.
                        dout_d       = wr ? din : mem_q[addr];
                    end
                end
            end
            ST_CLEAR: begin
                mem_we_c    = 1'b1;
                mem_waddr_c = cnt_q[ADDR_W-1:0];
                mem_wdata_c = '0;
                cnt_d       = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An edge seen while reset is held must not disturb memory.
        if (rst) begin
            mem_we_c = 1'b0;
        end
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[mem_waddr_c] <= mem_wdata_c;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;

endmodule
